// File: rtl/axi_lite_bram_port.sv
// ---------------------------------------------------------------------------
// axi_lite_bram_port
//
// Purpose: AXI-lite slave that fronts one single-port synchronous BRAM.
// Reads and writes share the BRAM port, and a round-robin arbiter picks one
// of them per cycle. A BRAM access is issued in the same cycle as the address
// handshake. The response (B or R) appears one cycle later.
//
// Ports:
//   clk, rstn                  clock, asynchronous active-low reset
//   aw_*/w_*/b_*               AXI-lite write address, data and response
//   ar_*/r_*                   AXI-lite read address and data
//   bram_en/we/addr/wrdata     BRAM command side, driven combinationally
//   bram_rddata                BRAM read data, one cycle after a read enable
// ---------------------------------------------------------------------------
module axi_lite_bram_port #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 64,
  parameter int BRAM_ADDR_WIDTH = 12
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [ADDR_WIDTH-1:0]      aw_addr,
  input  logic                       aw_valid,
  output logic                       aw_ready,
  input  logic [DATA_WIDTH-1:0]      w_data,
  input  logic [DATA_WIDTH/8-1:0]    w_strb,
  input  logic                       w_valid,
  output logic                       w_ready,
  output logic [1:0]                 b_resp,
  output logic                       b_valid,
  input  logic                       b_ready,
  input  logic [ADDR_WIDTH-1:0]      ar_addr,
  input  logic                       ar_valid,
  output logic                       ar_ready,
  output logic [DATA_WIDTH-1:0]      r_data,
  output logic [1:0]                 r_resp,
  output logic                       r_valid,
  input  logic                       r_ready,
  output logic                       bram_en,
  output logic [DATA_WIDTH/8-1:0]    bram_we,
  output logic [BRAM_ADDR_WIDTH-1:0] bram_addr,
  output logic [DATA_WIDTH-1:0]      bram_wrdata,
  input  logic [DATA_WIDTH-1:0]      bram_rddata
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int OFS    = $clog2(STRB_W);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RESP = 1'b1;

  logic [0:0]                 r_b_state;
  logic [0:0]                 r_r_state;
  logic                       r_prio_wr;      // 1: write wins the next tie
  logic                       r_rd_fresh;     // r_valid is in its first cycle
  logic [DATA_WIDTH-1:0]      r_rd_hold;
  logic [BRAM_ADDR_WIDTH-1:0] r_last_addr;
  logic [DATA_WIDTH-1:0]      r_last_wrdata;

  logic                       w_wr_ok;
  logic                       w_rd_ok;
  logic                       w_wr_grant;
  logic                       w_rd_grant;
  logic [BRAM_ADDR_WIDTH-1:0] w_aw_word;
  logic [BRAM_ADDR_WIDTH-1:0] w_ar_word;
  logic                       w_unused_addr;

  // Byte offset and the bits above the BRAM depth are dropped, so the BRAM
  // aliases across the whole address space.
  assign w_aw_word     = aw_addr[OFS +: BRAM_ADDR_WIDTH];
  assign w_ar_word     = ar_addr[OFS +: BRAM_ADDR_WIDTH];
  assign w_unused_addr = ^{aw_addr, ar_addr};

  // A side is eligible only if its response slot is free or being emptied
  // this cycle. AW and W are only ever taken together.
  assign w_wr_ok = aw_valid && w_valid && (!b_valid || b_ready);
  assign w_rd_ok = ar_valid && (!r_valid || r_ready);

  // The grants are gated by rstn so the BRAM command drops the moment reset
  // asserts, not at the next clock edge.
  assign w_wr_grant = rstn && w_wr_ok && (!w_rd_ok || r_prio_wr);
  assign w_rd_grant = rstn && w_rd_ok && (!w_wr_ok || !r_prio_wr);

  assign aw_ready = w_wr_grant;
  assign w_ready  = w_wr_grant;
  assign ar_ready = w_rd_grant;

  // The BRAM command is issued in the grant cycle. When idle, addr and
  // wrdata keep their last values so the outputs stay deterministic.
  always_comb begin
    bram_en     = w_wr_grant || w_rd_grant;
    bram_we     = w_wr_grant ? w_strb : '0;
    bram_addr   = r_last_addr;
    bram_wrdata = r_last_wrdata;
    if (w_wr_grant) begin
      bram_addr   = w_aw_word;
      bram_wrdata = w_data;
    end else if (w_rd_grant) begin
      bram_addr   = w_ar_word;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_last_addr   <= '0;
      r_last_wrdata <= '0;
    end else begin
      if (w_wr_grant) begin
        r_last_addr   <= w_aw_word;
        r_last_wrdata <= w_data;
      end else if (w_rd_grant) begin
        r_last_addr   <= w_ar_word;
      end
    end
  end

  // The side just served yields the next tie to the other side.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_prio_wr <= 1'b1;
    end else if (w_wr_grant) begin
      r_prio_wr <= 1'b0;
    end else if (w_rd_grant) begin
      r_prio_wr <= 1'b1;
    end
  end

  // Write response FSM. A grant while in RESP implies that b_ready emptied
  // the slot this cycle, so the FSM stays in RESP back-to-back.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_b_state <= ST_IDLE;
    end else begin
      case (r_b_state)
        ST_IDLE: if (w_wr_grant) r_b_state <= ST_RESP;
        ST_RESP: if (b_ready && !w_wr_grant) r_b_state <= ST_IDLE;
        default: r_b_state <= ST_IDLE;
      endcase
    end
  end

  // Read response FSM, structured the same way as the write side.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_r_state <= ST_IDLE;
    end else begin
      case (r_r_state)
        ST_IDLE: if (w_rd_grant) r_r_state <= ST_RESP;
        ST_RESP: if (r_ready && !w_rd_grant) r_r_state <= ST_IDLE;
        default: r_r_state <= ST_IDLE;
      endcase
    end
  end

  // In the first response cycle the BRAM output is passed straight through
  // and also captured. After that the hold register keeps r_data stable even
  // though later BRAM accesses change bram_rddata.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rd_fresh <= 1'b0;
      r_rd_hold  <= '0;
    end else begin
      r_rd_fresh <= w_rd_grant;
      if (r_rd_fresh) begin
        r_rd_hold <= bram_rddata;
      end
    end
  end

  assign b_valid = (r_b_state == ST_RESP);
  assign r_valid = (r_r_state == ST_RESP);
  assign r_data  = r_rd_fresh ? bram_rddata : r_rd_hold;
  assign b_resp  = 2'b00;
  assign r_resp  = 2'b00;

endmodule

// File: tb/tb_axi_lite_bram_port.sv
// ---------------------------------------------------------------------------
// tb_axi_lite_bram_port
//
// Purpose: directed, table-driven bench for axi_lite_bram_port, backed by a
// behavioural read-first BRAM. Inputs change on the falling clock edge, and
// outputs are sampled 1 ns later, well away from the rising edge.
// ---------------------------------------------------------------------------
module tb_axi_lite_bram_port;

  logic        clk;
  logic        rstn;
  logic [31:0] aw_addr;
  logic        aw_valid;
  logic        aw_ready;
  logic [63:0] w_data;
  logic [7:0]  w_strb;
  logic        w_valid;
  logic        w_ready;
  logic [1:0]  b_resp;
  logic        b_valid;
  logic        b_ready;
  logic [31:0] ar_addr;
  logic        ar_valid;
  logic        ar_ready;
  logic [63:0] r_data;
  logic [1:0]  r_resp;
  logic        r_valid;
  logic        r_ready;
  logic        bram_en;
  logic [7:0]  bram_we;
  logic [11:0] bram_addr;
  logic [63:0] bram_wrdata;
  logic [63:0] bram_rddata;

  int n_chk = 0;
  int n_err = 0;

  logic [63:0] mem [0:4095];

  axi_lite_bram_port #(
    .ADDR_WIDTH(32), .DATA_WIDTH(64), .BRAM_ADDR_WIDTH(12)
  ) dut (
    .clk(clk), .rstn(rstn),
    .aw_addr(aw_addr), .aw_valid(aw_valid), .aw_ready(aw_ready),
    .w_data(w_data), .w_strb(w_strb), .w_valid(w_valid), .w_ready(w_ready),
    .b_resp(b_resp), .b_valid(b_valid), .b_ready(b_ready),
    .ar_addr(ar_addr), .ar_valid(ar_valid), .ar_ready(ar_ready),
    .r_data(r_data), .r_resp(r_resp), .r_valid(r_valid), .r_ready(r_ready),
    .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
    .bram_wrdata(bram_wrdata), .bram_rddata(bram_rddata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Read-first single-port BRAM model
  always @(posedge clk) begin
    if (bram_en) begin
      for (int b = 0; b < 8; b++) begin
        if (bram_we[b]) mem[bram_addr][b*8 +: 8] <= bram_wrdata[b*8 +: 8];
      end
      bram_rddata <= mem[bram_addr];
    end
  end

  typedef struct {
    logic        awv;
    logic [31:0] awa;
    logic [63:0] wd;
    logic [7:0]  ws;
    logic        arv;
    logic [31:0] ara;
    logic        br;
    logic        rr;
    logic        e_awr;
    logic        e_arr;
    logic        e_en;
    logic [7:0]  e_we;
    logic [11:0] e_addr;
    logic [63:0] e_wd;
    logic        e_bv;
    logic        e_rv;
    logic [63:0] e_rd;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic awv, input logic [31:0] awa, input logic [63:0] wd,
                       input logic [7:0] ws, input logic arv, input logic [31:0] ara,
                       input logic br, input logic rr);
    aw_valid = awv;
    w_valid  = awv;
    aw_addr  = awa;
    w_data   = wd;
    w_strb   = ws;
    ar_valid = arv;
    ar_addr  = ara;
    b_ready  = br;
    r_ready  = rr;
  endtask

  task automatic apply_reset();
    drive(1'b0, 32'h0, 64'h0, 8'h00, 1'b0, 32'h0, 1'b1, 1'b1);
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    for (int a = 0; a < 4096; a++) mem[a] = 64'h0;
    bram_rddata = 64'h0;

    // Columns: awv awa wd ws | arv ara | br rr ||
    //          awr arr en we addr wrdata | bv rv rdata
    vecs[0]  = '{0, 32'h0,        64'h0,                  8'h00, 0, 32'h0,        1, 1,
                 0, 0, 0, 8'h00, 12'd0, 64'h0,                  0, 0, 64'h0};
    vecs[1]  = '{1, 32'h10,       64'h1122334455667788,   8'hFF, 0, 32'h0,        1, 1,
                 1, 0, 1, 8'hFF, 12'd2, 64'h1122334455667788,   0, 0, 64'h0};
    vecs[2]  = '{0, 32'h0,        64'h0,                  8'h00, 1, 32'h10,       1, 1,
                 0, 1, 1, 8'h00, 12'd2, 64'h1122334455667788,   1, 0, 64'h0};
    vecs[3]  = '{1, 32'h10,       64'hAAAAAAAABBBBBBBB,   8'h0F, 0, 32'h0,        1, 1,
                 1, 0, 1, 8'h0F, 12'd2, 64'hAAAAAAAABBBBBBBB,   0, 1, 64'h1122334455667788};
    vecs[4]  = '{0, 32'h0,        64'h0,                  8'h00, 1, 32'h10,       1, 1,
                 0, 1, 1, 8'h00, 12'd2, 64'hAAAAAAAABBBBBBBB,   1, 0, 64'h0};
    vecs[5]  = '{0, 32'h0,        64'h0,                  8'h00, 0, 32'h0,        1, 1,
                 0, 0, 0, 8'h00, 12'd2, 64'hAAAAAAAABBBBBBBB,   0, 1, 64'h11223344BBBBBBBB};
    vecs[6]  = '{1, 32'h18,       64'hDEADBEEFCAFEF00D,   8'h00, 0, 32'h0,        1, 1,
                 1, 0, 1, 8'h00, 12'd3, 64'hDEADBEEFCAFEF00D,   0, 0, 64'h0};
    vecs[7]  = '{0, 32'h0,        64'h0,                  8'h00, 0, 32'h0,        1, 1,
                 0, 0, 0, 8'h00, 12'd3, 64'hDEADBEEFCAFEF00D,   1, 0, 64'h0};
    vecs[8]  = '{0, 32'h0,        64'h0,                  8'h00, 1, 32'h80000015, 1, 1,
                 0, 1, 1, 8'h00, 12'd2, 64'hDEADBEEFCAFEF00D,   0, 0, 64'h0};
    vecs[9]  = '{0, 32'h0,        64'h0,                  8'h00, 0, 32'h0,        1, 1,
                 0, 0, 0, 8'h00, 12'd2, 64'hDEADBEEFCAFEF00D,   0, 1, 64'h11223344BBBBBBBB};
    vecs[10] = '{1, 32'h28,       64'h5555555555555555,   8'hFF, 1, 32'h18,       1, 1,
                 1, 0, 1, 8'hFF, 12'd5, 64'h5555555555555555,   0, 0, 64'h0};
    vecs[11] = '{1, 32'h28,       64'h6666666666666666,   8'hFF, 1, 32'h18,       1, 1,
                 0, 1, 1, 8'h00, 12'd3, 64'h5555555555555555,   1, 0, 64'h0};
    vecs[12] = '{1, 32'h28,       64'h6666666666666666,   8'hFF, 0, 32'h0,        1, 1,
                 1, 0, 1, 8'hFF, 12'd5, 64'h6666666666666666,   0, 1, 64'h0};
    vecs[13] = '{0, 32'h0,        64'h0,                  8'h00, 0, 32'h0,        1, 1,
                 0, 0, 0, 8'h00, 12'd5, 64'h6666666666666666,   1, 0, 64'h0};

    // While reset is held, every valid input is high, yet nothing may be
    // granted or issued to the BRAM.
    rstn = 1'b0;
    drive(1'b1, 32'h10, 64'h1, 8'hFF, 1'b1, 32'h10, 1'b1, 1'b1);
    #3;
    chk("rst_bvalid", b_valid, 1'b0);
    chk("rst_rvalid", r_valid, 1'b0);
    chk("rst_en", bram_en, 1'b0);
    chk("rst_we", bram_we, 8'h00);
    chk("rst_awready", aw_ready, 1'b0);
    chk("rst_arready", ar_ready, 1'b0);
    apply_reset();

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      drive(vecs[i].awv, vecs[i].awa, vecs[i].wd, vecs[i].ws,
            vecs[i].arv, vecs[i].ara, vecs[i].br, vecs[i].rr);
      #1;
      chk($sformatf("v%0d_awready", i), aw_ready, vecs[i].e_awr);
      chk($sformatf("v%0d_wready", i), w_ready, vecs[i].e_awr);
      chk($sformatf("v%0d_arready", i), ar_ready, vecs[i].e_arr);
      chk($sformatf("v%0d_en", i), bram_en, vecs[i].e_en);
      chk($sformatf("v%0d_we", i), bram_we, vecs[i].e_we);
      chk($sformatf("v%0d_addr", i), bram_addr, vecs[i].e_addr);
      chk($sformatf("v%0d_wrdata", i), bram_wrdata, vecs[i].e_wd);
      chk($sformatf("v%0d_bvalid", i), b_valid, vecs[i].e_bv);
      chk($sformatf("v%0d_rvalid", i), r_valid, vecs[i].e_rv);
      if (vecs[i].e_bv) chk($sformatf("v%0d_bresp", i), b_resp, 2'b00);
      if (vecs[i].e_rv) begin
        chk($sformatf("v%0d_rdata", i), r_data, vecs[i].e_rd);
        chk($sformatf("v%0d_rresp", i), r_resp, 2'b00);
      end
    end

    // Contention: both sides always valid. The grants alternate W,R,W,...
    // starting with W after reset, with one BRAM access in every cycle.
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive(1'b1, 32'h20, 64'h0F0F0F0F00000000 + 64'(i), 8'hFF, 1'b1, 32'h10, 1'b1, 1'b1);
      #1;
      chk($sformatf("ct%0d_awready", i), aw_ready, (i % 2) == 0);
      chk($sformatf("ct%0d_arready", i), ar_ready, (i % 2) == 1);
      chk($sformatf("ct%0d_en", i), bram_en, 1'b1);
      chk($sformatf("ct%0d_addr", i), bram_addr, ((i % 2) == 0) ? 12'd4 : 12'd2);
      chk($sformatf("ct%0d_we", i), bram_we, ((i % 2) == 0) ? 8'hFF : 8'h00);
      chk($sformatf("ct%0d_bvalid", i), b_valid, (i % 2) == 1);
      chk($sformatf("ct%0d_rvalid", i), r_valid, (i > 0) && ((i % 2) == 0));
      if ((i > 0) && ((i % 2) == 0)) chk($sformatf("ct%0d_rdata", i), r_data, 64'h11223344BBBBBBBB);
    end
    @(negedge clk);
    drive(1'b0, 32'h0, 64'h0, 8'h00, 1'b0, 32'h0, 1'b1, 1'b1);
    @(negedge clk);

    // Backpressure: the R channel stalls while writes keep streaming to
    // another address, so the BRAM output changes under the held response.
    apply_reset();
    @(negedge clk);
    drive(1'b0, 32'h0, 64'h0, 8'h00, 1'b1, 32'h10, 1'b1, 1'b0);
    #1;
    chk("bp_first_arready", ar_ready, 1'b1);
    chk("bp_first_en", bram_en, 1'b1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      drive(1'b1, 32'h40, 64'h0101010101010101 * 64'(k + 1), 8'hFF, 1'b1, 32'h10, 1'b1, 1'b0);
      #1;
      chk($sformatf("bp%0d_rvalid", k), r_valid, 1'b1);
      chk($sformatf("bp%0d_rdata", k), r_data, 64'h11223344BBBBBBBB);
      chk($sformatf("bp%0d_arready", k), ar_ready, 1'b0);
      chk($sformatf("bp%0d_awready", k), aw_ready, 1'b1);
      chk($sformatf("bp%0d_we", k), bram_we, 8'hFF);
      chk($sformatf("bp%0d_addr", k), bram_addr, 12'd8);
    end
    @(negedge clk);
    drive(1'b0, 32'h0, 64'h0, 8'h00, 1'b1, 32'h10, 1'b1, 1'b1);
    #1;
    chk("bp_release_arready", ar_ready, 1'b1);
    chk("bp_release_en", bram_en, 1'b1);
    chk("bp_release_we", bram_we, 8'h00);
    chk("bp_release_rdata", r_data, 64'h11223344BBBBBBBB);
    @(negedge clk);
    drive(1'b0, 32'h0, 64'h0, 8'h00, 1'b0, 32'h0, 1'b1, 1'b1);
    #1;
    chk("bp_next_rvalid", r_valid, 1'b1);
    chk("bp_next_rdata", r_data, 64'h11223344BBBBBBBB);
    @(negedge clk);
    #1;
    chk("bp_drain_rvalid", r_valid, 1'b0);

    // Reset in mid-cycle, with both responses pending and a read being issued
    @(negedge clk);
    drive(1'b1, 32'h30, 64'h7777777777777777, 8'hFF, 1'b0, 32'h0, 1'b0, 1'b1);
    #1;
    chk("rs_w_awready", aw_ready, 1'b1);
    @(negedge clk);
    drive(1'b0, 32'h0, 64'h0, 8'h00, 1'b1, 32'h10, 1'b0, 1'b0);
    #1;
    chk("rs_r_arready", ar_ready, 1'b1);
    chk("rs_r_bvalid", b_valid, 1'b1);
    @(negedge clk);
    drive(1'b0, 32'h0, 64'h0, 8'h00, 1'b1, 32'h10, 1'b0, 1'b1);
    #1;
    chk("rs_pre_bvalid", b_valid, 1'b1);
    chk("rs_pre_rvalid", r_valid, 1'b1);
    chk("rs_pre_en", bram_en, 1'b1);
    #1;
    rstn = 1'b0;
    #1;
    chk("rs_async_bvalid", b_valid, 1'b0);
    chk("rs_async_rvalid", r_valid, 1'b0);
    chk("rs_async_en", bram_en, 1'b0);
    chk("rs_async_we", bram_we, 8'h00);
    chk("rs_async_arready", ar_ready, 1'b0);
    @(negedge clk);
    drive(1'b0, 32'h0, 64'h0, 8'h00, 1'b0, 32'h0, 1'b1, 1'b1);
    @(negedge clk);
    rstn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("rs_post%0d_bvalid", k), b_valid, 1'b0);
      chk($sformatf("rs_post%0d_rvalid", k), r_valid, 1'b0);
      chk($sformatf("rs_post%0d_en", k), bram_en, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
